trace_emitter: RTL
==================

Name: trace_emitter

Overview:
- Hardware commit-trace source for the single-cycle 16-bit CPU. It captures one retired-instruction event per cycle from the cpu datapath: register write, load, store, branch/NOP, or halt.
- Events are buffered as records in a small FIFO and serialized out as 16-bit words over a valid/ready stream.
- An off-chip or bench-side reader reconstructs the INUM/PC/REG/ADDR/VALUE trace from this stream, so the trace is available on silicon and does not depend on hierarchical probing.

Parameters:
- DEPTH, 8, record FIFO depth; power of two, >=2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  trace enable; commits are ignored while low
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  16  PC of the retiring instruction
- commit_regwrite  in  1  register file written
- commit_reg  in  4  destination register
- commit_wdata  in  16  register write data
- commit_memread  in  1  load
- commit_memwrite  in  1  store
- commit_addr  in  16  memory address (ALU result)
- commit_sdata  in  16  store data
- commit_halt  in  1  halt instruction
- t_valid  out  1  stream word valid
- t_ready  in  1  downstream accepts word
- t_data  out  16  stream word
- t_last  out  1  last word of the current record
- stall_o  out  1  request for the cpu to hold PC and suppress commit
- overflow  out  1  sticky: at least one record was dropped
- drop_count  out  DROP_W  dropped records, saturating at all-ones
- trace_done  out  1  sticky: HALT record fully transmitted

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. Reset clears all outputs to 0, clears the FIFO, sets seq=0, and puts the serializer in IDLE.
- Classification at capture, highest priority first:
  - regwrite && memread -> LD (type 2)
  - regwrite -> REG (1)
  - halt -> HALT (4)
  - memwrite -> ST (3)
  - otherwise -> NOP (0)
- Record fields: {type[2:0], reg[3:0], seq[8:0], pc, value, addr}.
  - value = wdata for REG/LD; value = sdata for ST.
  - reg = 0 for ST/NOP/HALT.
- Push condition: commit_valid && en && !halted && count<DEPTH.
  - No same-cycle bypass: a pop in the same cycle does not free space for a push when full.
  - seq increments on every push and wraps at 512.
- Drop: a commit that meets all push conditions except count<DEPTH is dropped. On a drop, overflow<=1 and drop_count increments (saturating). seq is not incremented.
- halted is set when a HALT record is pushed. All later commits are ignored and are not counted as drops.
- stall_o = (count >= DEPTH-1). It is combinational from the registered count.
- Word order:
  - W0 header = {type, reg, seq}
  - W1 = pc
  - W2 = value (REG/LD/ST only)
  - W3 = addr (LD/ST only)
- Words per record: NOP=2, HALT=2, REG=3, LD=4, ST=4. t_last is asserted only with the final word.
- Serializer FSM states: IDLE, HDR, PC, VAL, ADR.
  - IDLE -> HDR when the FIFO is non-empty.
  - A word advances only on the t_valid && t_ready handshake.
  - After the last word: return to HDR if the FIFO is still non-empty, otherwise IDLE. There is no bubble between back-to-back records.
  - The record is popped on its last-word handshake.
- Latency: a commit at edge N produces t_valid=1 with the header in cycle N+1 (registered output).
- Handshake rules:
  - t_data and t_last are stable while t_valid && !t_ready.
  - t_valid is never withdrawn once asserted, except by reset.
- trace_done<=1 on the HALT record's last-word handshake. It is sticky until reset.
- Reset mid-record: the partially sent record is discarded. t_valid=0 in the cycle after the reset edge. Restart begins at seq=0.
- en low does not affect records already queued; they drain normally.

Decomposition:
- trace_pkg holds:
  - type encodings TR_NOP/REG/LD/ST/HALT
  - per-type word count function
  - record struct (64 bits incl. seq)
  - header field positions
- Sub-module trace_fifo: synchronous FIFO of records with count output, parameterized by DEPTH.
- Classification, seq counter, drop logic and serializer FSM live in trace_emitter.

Test Plan:
1. Single REG record:
   - Stimulus: commit pc=0x0004, regwrite, reg=3, wdata=0x1234; t_ready=1.
   - Required: words 0x2600, 0x0004, 0x1234 in cycles N+1..N+3; t_last only on 0x1234.
2. LD under backpressure:
   - Stimulus: second commit is LD, reg=5, wdata=0xBEEF, addr=0x0040; t_ready=0 for 5 cycles.
   - Required: t_data holds 0x4A01 with t_valid=1 throughout the stall; then 0x4A01, pc, 0xBEEF, 0x0040 with t_last on the 4th word.
3. Overflow (DEPTH=8):
   - Stimulus: t_ready=0; 10 consecutive NOP commits.
   - Required: stall_o rises when count=7; 8 records held; overflow=1; drop_count=2; the first record drained after t_ready=1 has seq=0 and the last has seq=7.
4. Priority and halt:
   - Stimulus: commit with regwrite=1 and halt=1 -> REG record. Then commit halt, pc=0x0020 -> words 0x8000|seq, 0x0020.
   - Required: trace_done=1 in the cycle after the final handshake; later commits produce nothing and drop_count is unchanged.
5. Seq wrap:
   - Stimulus: 513 NOP commits with t_ready=1.
   - Required: the 513th header has seq field 0x000 and the 512th has 0x1FF.
6. Reset mid-record:
   - Stimulus: ST record with the header already accepted; rst_n=0 for one edge.
   - Required: t_valid=0, FIFO empty, overflow=0, trace_done=0. The next commit after release has header seq=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit-trace source: record layout, type codes, header field positions
// and the per-type stream word count.
package trace_pkg;

  typedef enum logic [2:0] {
    TR_NOP  = 3'd0,
    TR_REG  = 3'd1,
    TR_LD   = 3'd2,
    TR_ST   = 3'd3,
    TR_HALT = 3'd4
  } tr_type_e;

  // 64-bit record: 16-bit header fields, then pc, value, addr.
  typedef struct packed {
    tr_type_e    rtype;
    logic [3:0]  rd;
    logic [8:0]  seq;
    logic [15:0] pc;
    logic [15:0] value;
    logic [15:0] addr;
  } trace_rec_t;

  localparam int unsigned HDR_TYPE_LSB = 13;
  localparam int unsigned HDR_REG_LSB  = 9;
  localparam int unsigned HDR_SEQ_LSB  = 0;

  function automatic logic [2:0] words_of(tr_type_e t);
    logic [2:0] n;
    case (t)
      TR_REG:       n = 3'd3;
      TR_LD, TR_ST: n = 3'd4;
      default:      n = 3'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with occupancy count. Read data is the head entry, valid when not
// empty; pushes while full and pops while empty are ignored.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  trace_rec_t             i_data,
  input  logic                   i_pop,
  output trace_rec_t             o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/trace_emitter.sv
// Commit-trace source: classifies each retiring instruction into a record, queues it and
// serializes records as 16-bit words over a valid/ready stream.
module trace_emitter
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              commit_valid,
  input  logic [15:0]       commit_pc,
  input  logic              commit_regwrite,
  input  logic [3:0]        commit_reg,
  input  logic [15:0]       commit_wdata,
  input  logic              commit_memread,
  input  logic              commit_memwrite,
  input  logic [15:0]       commit_addr,
  input  logic [15:0]       commit_sdata,
  input  logic              commit_halt,
  output logic              t_valid,
  input  logic              t_ready,
  output logic [15:0]       t_data,
  output logic              t_last,
  output logic              stall_o,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              trace_done
);

  localparam int unsigned   CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StPc, StVal, StAdr} ser_state_e;

  ser_state_e        r_state;
  ser_state_e        w_state_next;
  logic [8:0]        r_seq;
  logic              r_halted;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;
  logic              r_trace_done;

  tr_type_e          w_type;
  trace_rec_t        w_rec_in;
  trace_rec_t        w_rec_out;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_commit;
  logic              w_push;
  logic              w_drop;
  logic              w_hs;
  logic              w_last;
  logic              w_pop;
  logic [1:0]        w_word_idx;
  logic [15:0]       w_hdr;
  logic [15:0]       w_word;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign w_commit = commit_valid && en && !r_halted;
  assign w_push   = w_commit && !w_full;
  assign w_drop   = w_commit && w_full;

  always_comb begin
    w_type = TR_NOP;
    if (commit_regwrite && commit_memread) w_type = TR_LD;
    else if (commit_regwrite)              w_type = TR_REG;
    else if (commit_halt)                  w_type = TR_HALT;
    else if (commit_memwrite)              w_type = TR_ST;
  end

  always_comb begin
    w_rec_in       = '0;
    w_rec_in.rtype = w_type;
    w_rec_in.seq   = r_seq;
    w_rec_in.pc    = commit_pc;
    case (w_type)
      TR_REG, TR_LD: begin
        w_rec_in.rd    = commit_reg;
        w_rec_in.value = commit_wdata;
      end
      TR_ST:   w_rec_in.value = commit_sdata;
      default: ;
    endcase
    if (w_type == TR_LD || w_type == TR_ST) w_rec_in.addr = commit_addr;
  end

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_push (w_push),
    .i_data (w_rec_in),
    .i_pop  (w_pop),
    .o_data (w_rec_out),
    .o_count(w_count),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  // IDLE presents the header as well, giving header-valid one cycle after the commit edge.
  assign t_valid = !w_empty;
  assign w_hs    = t_valid && t_ready;

  always_comb begin
    w_word_idx = 2'd0;
    case (r_state)
      StPc:    w_word_idx = 2'd1;
      StVal:   w_word_idx = 2'd2;
      StAdr:   w_word_idx = 2'd3;
      default: ;
    endcase
  end

  assign w_last = (({1'b0, w_word_idx} + 3'd1) == words_of(w_rec_out.rtype));
  assign w_pop  = w_hs && w_last;

  always_comb begin
    w_hdr                        = '0;
    w_hdr[HDR_TYPE_LSB +: 3]     = w_rec_out.rtype;
    w_hdr[HDR_REG_LSB +: 4]      = w_rec_out.rd;
    w_hdr[HDR_SEQ_LSB +: 9]      = w_rec_out.seq;
  end

  always_comb begin
    w_word = w_hdr;
    case (r_state)
      StPc:    w_word = w_rec_out.pc;
      StVal:   w_word = w_rec_out.value;
      StAdr:   w_word = w_rec_out.addr;
      default: ;
    endcase
  end

  assign t_data = t_valid ? w_word : '0;
  assign t_last = t_valid && w_last;

  always_comb begin
    w_state_next = r_state;
    if (w_empty) begin
      w_state_next = StIdle;
    end else if (w_hs) begin
      if (w_last) begin
        w_state_next = (w_count > CW'(1) || w_push) ? StHdr : StIdle;
      end else begin
        case (r_state)
          StIdle, StHdr: w_state_next = StPc;
          StPc:          w_state_next = StVal;
          StVal:         w_state_next = StAdr;
          default:       w_state_next = StIdle;
        endcase
      end
    end else if (r_state == StIdle) begin
      w_state_next = StHdr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_seq        <= '0;
      r_halted     <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_trace_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_seq <= r_seq + 9'd1;
        if (w_type == TR_HALT) r_halted <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
      end
      if (w_pop && w_rec_out.rtype == TR_HALT) r_trace_done <= 1'b1;
    end
  end

  assign stall_o    = (w_count >= STALL_LEVEL);
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign trace_done = r_trace_done;

endmodule
